onebc_inpcond: RTL and testbench
================================

# onebc_inpcond

Eight-channel input conditioner that sits directly upstream of the onebc core and drives its `ins_i` bus. Each raw external input is brought into the core clock domain through a two-flop synchronizer. It is then debounced by a per-channel consecutive-sample counter, so the core only ever sees clean, stable levels. A one-cycle change strobe per channel marks every accepted level transition, for edge-sensitive logic or a testbench scoreboard.

## Interface
- `WIDTH`, 8: number of input channels; matches the onebc input bus.
- `DEBOUNCE`, 4: consecutive synchronized cycles a new level must persist before acceptance; legal range 1..255.
- `clk_i` in 1: core clock, rising-edge active; same clock as onebc.
- `rst_i` in 1: reset, synchronous, active-high.
- `raw_i` in WIDTH: asynchronous external inputs (switches, buttons, other domains).
- `ins_o` out WIDTH: debounced stable levels; connects to onebc `ins_i`.
- `chg_o` out WIDTH: per-channel one-cycle strobe, high on the cycle `ins_o[n]` takes a new value.

## Operation
- Registers per channel:
  - `s1`, `s2`: synchronizer flops.
  - `stable`: drives `ins_o[n]`.
  - `cnt`: `max(1, clog2(DEBOUNCE))` bits.
  - `chg`: drives `chg_o[n]`.
  - All outputs come straight from flops; there is no combinational path from `raw_i` to any output.
- Every rising edge with `rst_i=0`:
  - `s1 <= raw_i[n]`.
  - `s2 <= s1`.
- Debounce counter, evaluated from pre-edge values:
  - If `s2 == stable`: `cnt <= 0`, `chg <= 0`.
  - If `s2 != stable` and `cnt == DEBOUNCE-1`: `stable <= s2`, `cnt <= 0`, `chg <= 1`.
  - If `s2 != stable` and `cnt < DEBOUNCE-1`: `cnt <= cnt+1`, `chg <= 0`.
- Any single synchronized sample equal to `stable` restarts the count from 0. Partial counts are never carried across a bounce.
- Channels are fully independent. Any subset may update on the same edge, and `chg_o` may carry several set bits.
- Rising and falling transitions are treated identically; `chg_o` does not encode direction.
- `DEBOUNCE=1`: a level is accepted on the first mismatching synchronized sample.
- Counter never exceeds `DEBOUNCE-1`, so there is no wrap-around.

## Timing
- Reset value of every output and internal flop: 0.
  - `ins_o=0x00`, `chg_o=0x00`; `s1`, `s2`, `cnt` all 0.
- `rst_i` sampled high clears everything on that edge, including mid-count. Reset wins over any simultaneous acceptance.
- The synchronizers are held at 0 while `rst_i` is high.
  - A `raw_i` bit already at 1 through reset is treated as a fresh 0→1 transition after release.
  - It is accepted DEBOUNCE+2 edges after the first edge with `rst_i=0`.
- Latency: `raw_i[n]` changes and stays; edge 1 is the first edge that samples the new value.
  - `s2` mismatch is visible from edge 3.
  - `ins_o[n]` and `chg_o[n]` update at edge DEBOUNCE+2.
  - With the default (4), that is edge 6.
- Minimum accepted pulse width is DEBOUNCE raw samples; DEBOUNCE-1 samples are always rejected.
- `chg_o[n]` is high for exactly one cycle, coincident with the first cycle of the new `ins_o[n]`.
- Back-to-back accepted transitions on one channel are at least DEBOUNCE cycles apart.
- Throughput: one sample per channel per cycle; no stalls or handshakes.

## Test plan
All scenarios use `DEBOUNCE=4` and an 8 ns period.

1. Reset with `raw_i=0xFF`, `rst_i=1` for 2 cycles:
   - `ins_o=0x00` and `chg_o=0x00` during reset and for 5 edges after release.
   - `ins_o=0xFF` and `chg_o=0xFF` at edge 6; `chg_o=0x00` on the next cycle.
2. Pulse-width threshold:
   - `raw_i=0x01` for 3 cycles, then 0x00 → `ins_o` stays 0x00 and `chg_o` never asserts.
   - Repeat with a 4-cycle pulse → `ins_o[0]` high at edge 6 and low 4 cycles later, with 2 single-cycle `chg_o[0]` strobes.
3. Walking one, mirroring the core's bench:
   - Stimulus: `raw_i` = 0x01, 0x02, …, 0x80, then 0x00, each held 16 cycles.
   - `ins_o` reproduces each value 6 edges after its application.
   - `chg_o` shows the falling bit and rising bit together, e.g. 0x03 on the 0x01→0x02 step.
4. Bounce: `raw_i[3]` toggles every cycle for 20 cycles, then holds 1:
   - No `chg_o` during the bounce.
   - `ins_o[3]` rises exactly 6 edges after the first steady-1 sample edge, with a single strobe.
5. Reset mid-count:
   - `raw_i=0x80` held; `rst_i` pulsed for 1 cycle at edge 4 → `ins_o=0x00` and counter cleared.
   - `ins_o[7]` rises 6 edges after release, not earlier.
6. Simultaneous channels, starting from `ins_o=0x80`:
   - Stimulus: `raw_i` changes to 0x01 in one step.
   - At edge 6, `ins_o=0x01` and `chg_o=0x81` for one cycle.

Source files
------------

// File: rtl/onebc_inpcond.sv
// onebc_inpcond: eight-channel input conditioner feeding the onebc core.
// Each raw input passes through a two-flop synchronizer and a per-channel
// consecutive-sample debouncer. Outputs are driven only from flops: ins_o
// carries the accepted stable levels and chg_o strobes for one cycle on every
// accepted transition in either direction.
module onebc_inpcond #(
  parameter int WIDTH    = 8,
  parameter int DEBOUNCE = 4
) (
  input  logic             clk_i,
  input  logic             rst_i,
  input  logic [WIDTH-1:0] raw_i,
  output logic [WIDTH-1:0] ins_o,
  output logic [WIDTH-1:0] chg_o
);

  // A single-bit counter is kept even for DEBOUNCE=1 so the datapath shape
  // does not change; with DEBOUNCE=1 it simply never leaves zero.
  localparam int CNT_W = (DEBOUNCE > 1) ? $clog2(DEBOUNCE) : 1;
  localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(DEBOUNCE - 1);
  localparam logic [CNT_W-1:0] CNT_ONE  = CNT_W'(1);
  localparam logic [CNT_W-1:0] CNT_ZERO = CNT_W'(0);

  // Synchronizer stages.
  logic [WIDTH-1:0]            sync1_r;
  logic [WIDTH-1:0]            sync2_r;

  // Debounce state.
  logic [WIDTH-1:0]            stable_r;
  logic [WIDTH-1:0][CNT_W-1:0] cnt_r;
  logic [WIDTH-1:0]            chg_r;

  // Next-state values computed from the pre-edge register contents.
  logic [WIDTH-1:0]            stable_nxt_s;
  logic [WIDTH-1:0][CNT_W-1:0] cnt_nxt_s;
  logic [WIDTH-1:0]            chg_nxt_s;

  // Per-channel debounce decision: a synchronized sample equal to the stable
  // level restarts the run; DEBOUNCE consecutive mismatches accept the level.
  // The accept test uses >= so an out-of-range count (only reachable through
  // a corrupted flop when DEBOUNCE is not a power of two) recovers at once
  // instead of counting through the unused codes.
  always_comb begin
    stable_nxt_s = stable_r;
    cnt_nxt_s    = {(WIDTH*CNT_W){1'b0}};
    chg_nxt_s    = {WIDTH{1'b0}};
    for (int n = 0; n < WIDTH; n++) begin
      if (sync2_r[n] == stable_r[n]) begin
        cnt_nxt_s[n] = CNT_ZERO;
        chg_nxt_s[n] = 1'b0;
      end else if (cnt_r[n] >= CNT_LAST) begin
        stable_nxt_s[n] = sync2_r[n];
        cnt_nxt_s[n]    = CNT_ZERO;
        chg_nxt_s[n]    = 1'b1;
      end else begin
        cnt_nxt_s[n] = cnt_r[n] + CNT_ONE;
        chg_nxt_s[n] = 1'b0;
      end
    end
  end

  // Register update; reset clears synchronizers and debounce state alike,
  // so a reset edge overrides any acceptance that would coincide with it.
  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      sync1_r  <= {WIDTH{1'b0}};
      sync2_r  <= {WIDTH{1'b0}};
      stable_r <= {WIDTH{1'b0}};
      cnt_r    <= {(WIDTH*CNT_W){1'b0}};
      chg_r    <= {WIDTH{1'b0}};
    end else begin
      sync1_r  <= raw_i;
      sync2_r  <= sync1_r;
      stable_r <= stable_nxt_s;
      cnt_r    <= cnt_nxt_s;
      chg_r    <= chg_nxt_s;
    end
  end

  assign ins_o = stable_r;
  assign chg_o = chg_r;

endmodule

// File: tb/tb_onebc_inpcond.sv
// Testbench for onebc_inpcond (WIDTH=8, DEBOUNCE=4, 8 ns clock).
// A sample-history reference model predicts ins_o/chg_o every cycle; each
// scenario task also checks the directed timing points it is about.
module tb_onebc_inpcond;

  localparam int DEB = 4;

  logic       clk;
  logic       rst;
  logic [7:0] raw;
  logic [7:0] ins_o;
  logic [7:0] chg_o;

  int errors;
  int checks;

  // Reference model state: recent raw samples and synchronized samples.
  logic [7:0] raw_hist[$];
  logic [7:0] syn_hist[$];
  logic [7:0] mdl_ins;
  logic [7:0] mdl_chg;
  logic [7:0] mdl_syn;
  logic       mdl_all;

  onebc_inpcond #(.WIDTH(8), .DEBOUNCE(DEB)) dut (
    .clk_i(clk),
    .rst_i(rst),
    .raw_i(raw),
    .ins_o(ins_o),
    .chg_o(chg_o)
  );

  initial clk = 1'b0;
  always #4 clk = ~clk;

  // Model of one clock edge: the level seen by the debouncer is the raw
  // sample taken two edges earlier (zero if that is before reset release);
  // a channel flips when its last DEB seen samples all differ from it.
  task automatic model_step;
    if (rst) begin
      raw_hist.delete();
      syn_hist.delete();
      mdl_ins = 8'h00;
      mdl_chg = 8'h00;
    end else begin
      mdl_syn = (raw_hist.size() >= 2) ? raw_hist[raw_hist.size()-2] : 8'h00;
      raw_hist.push_back(raw);
      if (raw_hist.size() > 4) void'(raw_hist.pop_front());
      syn_hist.push_back(mdl_syn);
      if (syn_hist.size() > DEB) void'(syn_hist.pop_front());
      mdl_chg = 8'h00;
      for (int n = 0; n < 8; n++) begin
        mdl_all = (syn_hist.size() == DEB);
        foreach (syn_hist[k]) if (syn_hist[k][n] == mdl_ins[n]) mdl_all = 1'b0;
        if (mdl_all) begin
          mdl_ins[n] = ~mdl_ins[n];
          mdl_chg[n] = 1'b1;
        end
      end
    end
  endtask

  // Advance one edge; outputs are sampled at the following falling edge.
  task automatic tick;
    @(posedge clk);
    model_step();
    @(negedge clk);
  endtask

  task automatic do_reset;
    rst = 1'b1;
    raw = 8'h00;
    tick();
    tick();
    rst = 1'b0;
    tick();
  endtask

  task automatic test_reset;
    raw = 8'hFF;
    rst = 1'b1;
    for (int c = 0; c < 2; c++) begin
      tick();
      checks++;
      if (ins_o !== 8'h00 || chg_o !== 8'h00) begin
        errors++;
        $display("FAIL reset_hold: ins_o=%h chg_o=%h expected ins_o=00 chg_o=00", ins_o, chg_o);
      end
    end
    rst = 1'b0;
    for (int e = 1; e <= 7; e++) begin
      tick();
      checks++;
      if (ins_o !== ((e >= 6) ? 8'hFF : 8'h00) || chg_o !== ((e == 6) ? 8'hFF : 8'h00)) begin
        errors++;
        $display("FAIL reset_release edge %0d: ins_o=%h chg_o=%h expected ins_o=%h chg_o=%h",
                 e, ins_o, chg_o, (e >= 6) ? 8'hFF : 8'h00, (e == 6) ? 8'hFF : 8'h00);
      end
      checks++;
      if (ins_o !== mdl_ins || chg_o !== mdl_chg) begin
        errors++;
        $display("FAIL reset_model edge %0d: ins_o=%h chg_o=%h expected %h %h", e, ins_o, chg_o, mdl_ins, mdl_chg);
      end
    end
  endtask

  task automatic test_pulse_width;
    int strobes;
    for (int len = 3; len <= 4; len++) begin
      do_reset();
      raw = 8'h01;
      strobes = 0;
      for (int e = 1; e <= 14; e++) begin
        tick();
        if (e == len) raw = 8'h00;
        if (chg_o[0] === 1'b1) strobes++;
        checks++;
        if (len == 3) begin
          if (ins_o !== 8'h00 || chg_o !== 8'h00) begin
            errors++;
            $display("FAIL pulse3 edge %0d: ins_o=%h chg_o=%h expected 00 00", e, ins_o, chg_o);
          end
        end else begin
          if (ins_o !== ((e >= 6 && e < 10) ? 8'h01 : 8'h00) ||
              chg_o !== ((e == 6 || e == 10) ? 8'h01 : 8'h00)) begin
            errors++;
            $display("FAIL pulse4 edge %0d: ins_o=%h chg_o=%h", e, ins_o, chg_o);
          end
        end
        checks++;
        if (ins_o !== mdl_ins || chg_o !== mdl_chg) begin
          errors++;
          $display("FAIL pulse_model len %0d edge %0d: ins_o=%h chg_o=%h expected %h %h",
                   len, e, ins_o, chg_o, mdl_ins, mdl_chg);
        end
      end
      checks++;
      if (strobes != ((len == 4) ? 2 : 0)) begin
        errors++;
        $display("FAIL pulse_strobes len %0d: got %0d expected %0d", len, strobes, (len == 4) ? 2 : 0);
      end
    end
  endtask

  task automatic test_walking_one;
    logic [7:0] prev;
    logic [7:0] val;
    do_reset();
    prev = 8'h00;
    for (int v = 0; v <= 8; v++) begin
      val = (v < 8) ? (8'h01 << v) : 8'h00;
      raw = val;
      for (int e = 1; e <= 16; e++) begin
        tick();
        if (e == 5) begin
          checks++;
          if (ins_o !== prev || chg_o !== 8'h00) begin
            errors++;
            $display("FAIL walk_early val %h: ins_o=%h chg_o=%h expected %h 00", val, ins_o, chg_o, prev);
          end
        end
        if (e == 6) begin
          checks++;
          if (ins_o !== val || chg_o !== (prev ^ val)) begin
            errors++;
            $display("FAIL walk_edge6 val %h: ins_o=%h chg_o=%h expected %h %h", val, ins_o, chg_o, val, prev ^ val);
          end
        end
        checks++;
        if (ins_o !== mdl_ins || chg_o !== mdl_chg) begin
          errors++;
          $display("FAIL walk_model val %h edge %0d: ins_o=%h chg_o=%h expected %h %h",
                   val, e, ins_o, chg_o, mdl_ins, mdl_chg);
        end
      end
      prev = val;
    end
  endtask

  task automatic test_bounce;
    do_reset();
    for (int i = 1; i <= 20; i++) begin
      raw = (i % 2 == 1) ? 8'h08 : 8'h00;
      tick();
      checks++;
      if (chg_o !== 8'h00 || ins_o !== 8'h00) begin
        errors++;
        $display("FAIL bounce_quiet cycle %0d: ins_o=%h chg_o=%h expected 00 00", i, ins_o, chg_o);
      end
    end
    raw = 8'h08;
    for (int e = 1; e <= 8; e++) begin
      tick();
      checks++;
      if (ins_o !== ((e >= 6) ? 8'h08 : 8'h00) || chg_o !== ((e == 6) ? 8'h08 : 8'h00)) begin
        errors++;
        $display("FAIL bounce_settle edge %0d: ins_o=%h chg_o=%h", e, ins_o, chg_o);
      end
      checks++;
      if (ins_o !== mdl_ins || chg_o !== mdl_chg) begin
        errors++;
        $display("FAIL bounce_model edge %0d: ins_o=%h chg_o=%h expected %h %h", e, ins_o, chg_o, mdl_ins, mdl_chg);
      end
    end
  endtask

  task automatic test_reset_mid_count;
    do_reset();
    raw = 8'h80;
    tick();
    tick();
    tick();
    rst = 1'b1;
    tick();
    rst = 1'b0;
    checks++;
    if (ins_o !== 8'h00 || chg_o !== 8'h00) begin
      errors++;
      $display("FAIL midreset_clear: ins_o=%h chg_o=%h expected 00 00", ins_o, chg_o);
    end
    for (int r = 1; r <= 7; r++) begin
      tick();
      checks++;
      if (ins_o !== ((r >= 6) ? 8'h80 : 8'h00) || chg_o !== ((r == 6) ? 8'h80 : 8'h00)) begin
        errors++;
        $display("FAIL midreset_release edge %0d: ins_o=%h chg_o=%h", r, ins_o, chg_o);
      end
    end
  endtask

  task automatic test_simultaneous;
    do_reset();
    raw = 8'h80;
    repeat (8) tick();
    checks++;
    if (ins_o !== 8'h80) begin
      errors++;
      $display("FAIL simul_start: ins_o=%h expected 80", ins_o);
    end
    raw = 8'h01;
    for (int e = 1; e <= 7; e++) begin
      tick();
      checks++;
      if (ins_o !== ((e >= 6) ? 8'h01 : 8'h80) || chg_o !== ((e == 6) ? 8'h81 : 8'h00)) begin
        errors++;
        $display("FAIL simul edge %0d: ins_o=%h chg_o=%h", e, ins_o, chg_o);
      end
    end
  endtask

  task automatic test_random;
    int rate;
    do_reset();
    for (int c = 0; c < 900; c++) begin
      rate = (c < 300) ? 2 : ((c < 600) ? 4 : 12);
      rst = ($urandom_range(0, 79) == 0);
      for (int n = 0; n < 8; n++) begin
        if ($urandom_range(0, rate - 1) == 0) raw[n] = ~raw[n];
      end
      tick();
      checks++;
      if (ins_o !== mdl_ins || chg_o !== mdl_chg) begin
        errors++;
        $display("FAIL random cycle %0d: ins_o=%h chg_o=%h expected %h %h", c, ins_o, chg_o, mdl_ins, mdl_chg);
      end
    end
    rst = 1'b0;
  endtask

  initial begin
    errors = 0;
    checks = 0;
    rst = 1'b1;
    raw = 8'h00;
    mdl_ins = 8'h00;
    mdl_chg = 8'h00;
    @(negedge clk);
    test_reset();
    test_pulse_width();
    test_walking_one();
    test_bounce();
    test_reset_mid_count();
    test_simultaneous();
    test_random();
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
